// File: rtl/mem_responder.sv
// mem_responder: single-port data memory that answers processor read/write
// requests after a fixed number of wait cycles.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   mem_read   : read request (level)
//   mem_write  : write request (level)
//   data_addr  : byte address of the access
//   data_in    : write data
//   data_out   : registered read data, updated only on read completion
//   ready      : one-cycle completion strobe (high in DONE)
//   addr_err   : error flag for the completing access, only with ready
//   err_count  : saturating count of error completions
//   dbg_state  : current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a request is taken in IDLE on the first edge where mem_read or
// mem_write is high; address, data and request type are captured on that
// edge and later input changes are ignored. The access completes exactly
// LATENCY edges later with ready high for one cycle, then the block returns
// to IDLE, where a still-high request starts the next access.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        addr_err,
  output logic [7:0]  err_count,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] data_out_q;
  logic        ready_q;
  logic        addr_err_q;
  logic [7:0]  err_count_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Operands of the access that completes this cycle. With LATENCY=0 the
  // access finishes on its acceptance edge, so the live inputs are used;
  // otherwise the values captured at acceptance are used.
  logic          acc_rd;
  logic          acc_wr;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic          finish;
  logic          mem_we;
  logic [31:0]   rdata;

  always_comb begin
    acc_rd    = rd_q;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_rd    = mem_read;
      acc_wr    = mem_write;
      acc_addr  = data_addr;
      acc_wdata = data_in;
    end
    acc_idx = acc_addr[AW+1:2];
    acc_err = (acc_addr[1:0] != 2'b00) ||
              (acc_addr[31:2] >= 30'(DEPTH_WORDS)) ||
              (acc_rd && acc_wr);
    finish  = 1'b0;
    if (rst_n) begin
      if (state_q == IDLE && (mem_read || mem_write) && LATENCY == 0)
        finish = 1'b1;
      if (state_q == BUSY && cnt_q == 4'(LATENCY - 1))
        finish = 1'b1;
    end
    mem_we = finish && acc_wr && !acc_err;
    rdata  = mem[acc_idx];
  end

  // Memory array has no reset; its contents start undefined.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      data_out_q  <= 32'd0;
      ready_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q  <= data_addr;
            wdata_q <= data_in;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            cnt_q   <= 4'd0;
            state_q <= (LATENCY == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (finish) state_q <= DONE;
          else        cnt_q   <= cnt_q + 4'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (finish) begin
        ready_q    <= 1'b1;
        addr_err_q <= acc_err;
        if (acc_err && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        // Reads (including a read+write collision) reload data_out; an
        // error forces zero. Plain writes leave it alone.
        if (acc_rd) data_out_q <= acc_err ? 32'd0 : rdata;
      end
    end
  end

  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign addr_err  = addr_err_q;
  assign err_count = err_count_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256; data-memory size in 32-bit words, power of two, 16..4096.
REQ-002 Parameter LATENCY, default 2; wait cycles per access, 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mem_read  input  1  read request from processor, level-sensitive.
REQ-006 mem_write  input  1  write request from processor, level-sensitive.
REQ-007 data_addr  input  32  byte address of access.
REQ-008 data_in  input  32  write data.
REQ-009 data_out  output  32  registered read data.
REQ-010 ready  output  1  one-cycle completion strobe.
REQ-011 addr_err  output  1  error flag; high only together with ready.
REQ-012 err_count  output  8  saturating count of error completions.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-014 In IDLE, a request SHALL be accepted at edge k when mem_read or mem_write is high; data_addr, data_in and the request type are captured at edge k.
REQ-015 After acceptance with LATENCY>0, the FSM SHALL enter BUSY with wait counter 0, and increment the counter each cycle.
REQ-016 The FSM SHALL leave BUSY for DONE at edge k+LATENCY; with LATENCY=0 it goes IDLE->DONE at edge k.
REQ-017 ready SHALL be high for exactly the one cycle in DONE; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-018 Request inputs in BUSY and DONE SHALL be ignored; changes after edge k do not affect the access in flight.
REQ-019 A request still high in IDLE after DONE SHALL be accepted as a new access, giving a minimum period of LATENCY+2 cycles per access.
REQ-020 An access is in error if any of the following holds: captured address bits [1:0] nonzero; word index (addr>>2) >= DEPTH_WORDS; mem_read and mem_write both high at acceptance.
REQ-021 A valid write SHALL update the memory word at edge k+LATENCY; an error access SHALL leave memory unchanged.
REQ-022 A valid read SHALL load data_out at edge k+LATENCY.
REQ-023 data_out SHALL hold its value until the next read completion; writes do not change it.
REQ-024 An error read SHALL load data_out with 0.
REQ-025 addr_err SHALL equal 1 in the DONE cycle of an error access and 0 at all other times.
REQ-026 err_count SHALL increment on entry to an error DONE and saturate at 255.
REQ-027 Read of a word written by the immediately preceding access SHALL return the new data.
REQ-028 Memory contents SHALL not be initialised; reading a never-written word returns an undefined value.

Reset
REQ-029 While rst_n=0, the block SHALL force state IDLE, wait counter 0, ready 0, addr_err 0, data_out 0 and err_count 0, independent of clk.
REQ-030 Reset asserted in BUSY SHALL abort the access; a pending write SHALL not update memory.
REQ-031 The first request SHALL be accepted at the first rising edge at which rst_n=1 and a request is high.

Verification
REQ-032 LATENCY=2: write 0xDEADBEEF to 0x10 at edge 0, then read 0x10 -> ready high after edges 2 and 6; data_out=0xDEADBEEF after edge 6; addr_err=0.
REQ-033 Read of 0x13 (misaligned) -> ready=1 and addr_err=1 in the same cycle, data_out=0, err_count=1; memory unchanged.
REQ-034 DEPTH_WORDS=256: write to 0x400 -> addr_err=1; read of 0x3FC afterward returns its previous content.
REQ-035 mem_read and mem_write both high -> addr_err=1, no write; 256 such errors -> err_count=255.
REQ-036 Drop rst_n during BUSY of a write of 0x1234 to 0x20 -> ready stays 0; after reset, read of 0x20 does not return 0x1234 (pre-load 0x0 beforehand); all outputs 0.
REQ-037 LATENCY=0, mem_read held high for 6 cycles -> ready pulses every 2nd cycle, 3 completions, ready never high two cycles in a row.
